// File: rtl/icb_arbiter_param.sv
// N-master ICB arbiter: registered one-hot grant held until the owner's done, fixed-priority or
// round-robin selection, anti-starvation age boost and an optional hold-timeout watchdog.
module icb_arbiter_param #(
    parameter int                     NUM_M      = 5,
    parameter int                     SEL_W      = $clog2(NUM_M),
    parameter logic [NUM_M*SEL_W-1:0] PRIO_ORDER = {3'd4, 3'd1, 3'd0, 3'd3, 3'd2},
    parameter int                     STARVE_LIM = 64,
    parameter int                     MAX_HOLD   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rr_mode,
    input  logic [NUM_M-1:0] req,
    input  logic [NUM_M-1:0] done,
    output logic [NUM_M-1:0] grant,
    output logic [SEL_W-1:0] icb_sel,
    output logic             bus_busy,
    output logic             timeout_evt
);
    localparam int AGE_W  = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [AGE_W-1:0]  AGE_LIM   = AGE_W'(STARVE_LIM);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [SEL_W-1:0]  LAST_M    = SEL_W'(NUM_M - 1);
    localparam logic [SEL_W:0]    NUM_M_EXT = (SEL_W + 1)'(NUM_M);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [NUM_M-1:0]  grant_q, grant_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              tevt_q, tevt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [AGE_W-1:0]  age_q [NUM_M];
    logic [AGE_W-1:0]  age_d [NUM_M];

    logic [SEL_W-1:0]  win;
    logic [SEL_W:0]    rr_sum;
    logic              owner_done;
    logic              expire;
    logic              arb;

    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
        return (a == {AGE_W{1'b1}}) ? a : a + 1'b1;
    endfunction

    function automatic logic [SEL_W-1:0] ptr_next(input logic [SEL_W-1:0] p);
        return (p == LAST_M) ? '0 : p + 1'b1;
    endfunction

    // Winner search: loops run from the low-precedence end so the last hit is the real winner,
    // and a starved master (lowest index) overrides both normal policies.
    always_comb begin
        win    = '0;
        rr_sum = '0;
        if (rr_mode) begin
            for (int k = NUM_M - 1; k >= 0; k--) begin
                rr_sum = {1'b0, rr_ptr_q} + (SEL_W + 1)'(k);
                if (rr_sum >= NUM_M_EXT) rr_sum = rr_sum - NUM_M_EXT;
                if (req[rr_sum[SEL_W-1:0]]) win = rr_sum[SEL_W-1:0];
            end
        end else begin
            for (int k = NUM_M - 1; k >= 0; k--) begin
                if (req[PRIO_ORDER[(NUM_M-1-k)*SEL_W +: SEL_W]])
                    win = PRIO_ORDER[(NUM_M-1-k)*SEL_W +: SEL_W];
            end
        end
        if (STARVE_LIM != 0) begin
            for (int i = NUM_M - 1; i >= 0; i--) begin
                if (req[i] && (age_q[i] >= AGE_LIM)) win = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        rr_ptr_d   = rr_ptr_q;
        tevt_d     = 1'b0;
        hold_d     = hold_q;
        owner_done = done[sel_q];
        expire     = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
        arb        = (state_q == IDLE) || owner_done || expire;

        if (state_q == BUSY && expire && !owner_done) tevt_d = 1'b1;

        if (arb) begin
            hold_d = '0;
            if (|req) begin
                state_d  = BUSY;
                grant_d  = NUM_M'(1) << win;
                sel_d    = win;
                rr_ptr_d = ptr_next(win);
            end else begin
                state_d = IDLE;
                grant_d = '0;
            end
        end else if (MAX_HOLD != 0) begin
            hold_d = hold_q + 1'b1;
        end

        // Age restarts whenever the master stops waiting, including the edge that grants it.
        for (int i = 0; i < NUM_M; i++) begin
            if (STARVE_LIM != 0 && req[i] && !grant_q[i] && !grant_d[i])
                age_d[i] = age_inc(age_q[i]);
            else
                age_d[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            tevt_q   <= 1'b0;
            hold_q   <= '0;
            for (int i = 0; i < NUM_M; i++) age_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            tevt_q   <= tevt_d;
            hold_q   <= hold_d;
            for (int i = 0; i < NUM_M; i++) age_q[i] <= age_d[i];
        end
    end

    assign grant       = grant_q;
    assign icb_sel     = sel_q;
    assign bus_busy    = (state_q == BUSY);
    assign timeout_evt = tevt_q;

endmodule

// File: tb/tb_icb_arbiter_param.sv
// Bench for icb_arbiter_param: two instances (default parameters, and STARVE_LIM=8/MAX_HOLD=16)
// checked every cycle against a behavioural model plus directed literal expectations.
module tb_icb_arbiter_param;
    logic       clk;
    logic       rst_n;
    logic       rr_a, rr_b;
    logic [4:0] req_a, done_a, req_b, done_b;
    logic [4:0] grant_a, grant_b;
    logic [2:0] sel_a, sel_b;
    logic       busy_a, busy_b, tevt_a, tevt_b;

    int n_checks = 0;
    int n_err    = 0;

    localparam int PRIO [5] = '{4, 1, 0, 3, 2};

    icb_arbiter_param dut_a (
        .clk(clk), .rst_n(rst_n), .rr_mode(rr_a), .req(req_a), .done(done_a),
        .grant(grant_a), .icb_sel(sel_a), .bus_busy(busy_a), .timeout_evt(tevt_a)
    );

    icb_arbiter_param #(.STARVE_LIM(8), .MAX_HOLD(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .rr_mode(rr_b), .req(req_b), .done(done_b),
        .grant(grant_b), .icb_sel(sel_b), .bus_busy(busy_b), .timeout_evt(tevt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       busy;
        int       sel;
        int       rr;
        int       hold;
        bit       tevt;
        bit [4:0] grant;
        int       age [5];
    } mst_t;

    mst_t m_a, m_b;

    function automatic mst_t m_reset();
        mst_t s;
        s.busy = 0; s.sel = 0; s.rr = 0; s.hold = 0; s.tevt = 0; s.grant = '0;
        for (int i = 0; i < 5; i++) s.age[i] = 0;
        return s;
    endfunction

    function automatic mst_t m_step(mst_t s, bit [4:0] rq, bit [4:0] dn, bit rr, int sl, int mh);
        mst_t n;
        int   w;
        int   idx;
        bit   expire;
        bit   rel;
        n      = s;
        w      = -1;
        expire = s.busy && (mh != 0) && (s.hold == mh - 1);
        rel    = s.busy && (dn[s.sel] || expire);
        n.tevt = expire && !dn[s.sel];
        if (!s.busy || rel) begin
            if (sl != 0)
                for (int i = 0; i < 5; i++)
                    if (w < 0 && rq[i] && s.age[i] >= sl) w = i;
            if (w < 0 && rr)
                for (int k = 0; k < 5; k++) begin
                    idx = (s.rr + k) % 5;
                    if (w < 0 && rq[idx]) w = idx;
                end
            if (w < 0)
                for (int k = 0; k < 5; k++)
                    if (w < 0 && rq[PRIO[k]]) w = PRIO[k];
            n.hold = 0;
            if (w >= 0) begin
                n.busy = 1; n.sel = w; n.grant = 5'b00001 << w; n.rr = (w + 1) % 5;
            end else begin
                n.busy = 0; n.grant = '0;
            end
        end else if (mh != 0) begin
            n.hold = s.hold + 1;
        end
        for (int i = 0; i < 5; i++) begin
            if (rq[i] && !s.grant[i] && w != i)
                n.age[i] = (s.age[i] < sl) ? s.age[i] + 1 : s.age[i];
            else
                n.age[i] = 0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a <= m_reset();
            m_b <= m_reset();
        end else begin
            m_a <= m_step(m_a, req_a, done_a, rr_a, 64, 0);
            m_b <= m_step(m_b, req_b, done_b, rr_b, 8, 16);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_a_grant", int'(grant_a), int'(m_a.grant));
        chk("model_a_sel",   int'(sel_a),   m_a.sel);
        chk("model_a_busy",  int'(busy_a),  int'(m_a.busy));
        chk("model_a_tevt",  int'(tevt_a),  int'(m_a.tevt));
        chk("model_b_grant", int'(grant_b), int'(m_b.grant));
        chk("model_b_sel",   int'(sel_b),   m_b.sel);
        chk("model_b_busy",  int'(busy_b),  int'(m_b.busy));
        chk("model_b_tevt",  int'(tevt_b),  int'(m_b.tevt));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        rr_a = 1'b0; rr_b = 1'b0;
        req_a = '0; done_a = '0; req_b = '0; done_b = '0;
        tick();
        tick();
        chk("reset_grant", int'(grant_a), 0);
        chk("reset_sel",   int'(sel_a),   0);
        chk("reset_busy",  int'(busy_a),  0);
        chk("reset_tevt",  int'(tevt_b),  0);
        rst_n = 1'b1;
        tick();

        // Fixed priority, back-to-back handover from 0 to 2
        req_a = 5'b00101;
        tick();
        chk("t1_grant0", int'(grant_a), 5'b00001);
        chk("t1_sel0",   int'(sel_a),   0);
        req_a = 5'b00100; done_a = 5'b00001;
        tick();
        chk("t1_grant2", int'(grant_a), 5'b00100);
        chk("t1_busy",   int'(busy_a),  1);
        req_a = '0; done_a = 5'b00100;
        tick();
        done_a = '0;
        chk("t1_idle",     int'(busy_a), 0);
        chk("t1_sel_kept", int'(sel_a),  2);

        // Fixed priority order with all masters requesting
        req_a = 5'b11111;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_order%0d", k), int'(sel_a), PRIO[k]);
            req_a[PRIO[k]] = 1'b0;
            done_a = 5'b00001 << PRIO[k];
            tick();
        end
        done_a = '0;
        chk("t2_idle", int'(busy_a), 0);

        // Round robin with every request held
        do_reset();
        rr_a = 1'b1; req_a = 5'b11111;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t3_rr%0d", k), int'(sel_a), k % 5);
            tick();
            tick();
            done_a = 5'b00001 << (k % 5);
            tick();
            done_a = '0;
        end
        req_a = '0; done_a = 5'b00010;
        tick();
        done_a = '0; rr_a = 1'b0;
        chk("t3_idle", int'(busy_a), 0);

        // Starvation boost: master 2 overtakes a re-requesting master 4
        req_b = 5'b10100;
        tick();
        chk("t4_first4", int'(sel_b), 4);
        for (int r = 0; r < 2; r++) begin
            repeat (4) tick();
            done_b = 5'b10000;
            tick();
            done_b = '0;
            chk($sformatf("t4_round%0d", r), int'(sel_b), (r == 0) ? 4 : 2);
        end
        chk("t4_grant2", int'(grant_b), 5'b00100);
        req_b = 5'b10000;
        tick();
        done_b = 5'b00100;
        tick();
        chk("t4_back4", int'(sel_b), 4);
        req_b = '0; done_b = 5'b10000;
        tick();
        done_b = '0;
        chk("t4_idle", int'(busy_b), 0);

        // Watchdog releases master 1 after 16 cycles; pending master 3 takes over
        req_b = 5'b00010;
        tick();
        chk("t5_grant1", int'(grant_b), 5'b00010);
        req_b = 5'b01000;
        repeat (15) tick();
        chk("t5_still1", int'(grant_b), 5'b00010);
        chk("t5_no_tevt", int'(tevt_b), 0);
        tick();
        chk("t5_tevt",   int'(tevt_b),  1);
        chk("t5_grant3", int'(grant_b), 5'b01000);
        tick();
        chk("t5_tevt_pulse", int'(tevt_b), 0);
        req_b = '0; done_b = 5'b01000;
        tick();
        done_b = '0;
        chk("t5_idle", int'(busy_b), 0);

        // done coinciding with watchdog expiry counts as a normal release
        req_b = 5'b00001;
        tick();
        req_b = '0;
        repeat (15) tick();
        done_b = 5'b00001;
        tick();
        done_b = '0;
        chk("t5b_no_tevt", int'(tevt_b),  0);
        chk("t5b_grant",   int'(grant_b), 0);
        tick();
        chk("t5b_no_tevt2", int'(tevt_b), 0);

        // Non-owner done ignored, then async reset mid-transfer
        req_a = 5'b00010;
        tick();
        req_a = '0; done_a = 5'b00100;
        tick();
        done_a = '0;
        chk("t6_nonowner", int'(grant_a), 5'b00010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_grant", int'(grant_a), 0);
        chk("t6_async_busy",  int'(busy_a),  0);
        chk("t6_async_sel",   int'(sel_a),   0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_after", int'(grant_a), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
